// File: rtl/uart_tx_serializer.sv
// Bit-level UART transmitter: 8N1 by default, LSB first, one-cycle done pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 tx_start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 tx_done_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
    } state_t;
`endif

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 tx_next, busy_next, done_next;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity, parity_next;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            tx_done_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shift     <= shift_next;
            tx_o      <= tx_next;
            busy_o    <= busy_next;
            tx_done_o <= done_next;
`ifdef UART_TX_PARITY_EN
            parity    <= parity_next;
`endif
        end
    end

    assign tick = (cnt == CNT_MAX);

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        shift_next  = shift;
        done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity;
`endif
        case (state)
            IDLE: begin
                if (tx_start_i) begin
                    state_next  = START;
                    shift_next  = data_i;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^data_i;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift >> 1;
                    idx_next   = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Counter restarts on every state entry so each bit lasts exactly CLKS_PER_BIT.
        if (tick || (state_next != state) || (state == IDLE)) cnt_next = '0;
        else cnt_next = cnt + CNT_W'(1);

        // Line level is derived from the next state so tx_o stays a pure register output.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

endmodule
